// File: rtl/demux_32_buf_pkg.sv
// Shared constants for the demux_32_buf slice: data width, destination count,
// destination indices and accepted-word counter width.
package demux_32_buf_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned N_DEST = 4;
   localparam int unsigned CNT_W  = 16;

   localparam int unsigned CH_A = 0;
   localparam int unsigned CH_B = 1;
   localparam int unsigned CH_C = 2;
   localparam int unsigned CH_D = 3;

endpackage : demux_32_buf_pkg

// File: rtl/demux_32_slot.sv
// Single-entry holding slot: a data register plus a full flag.
// A load in the same cycle as a drain keeps the slot full with the new word.
module demux_32_slot
   import demux_32_buf_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              drain_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o
);

   logic [DATA_W-1:0] data_q;
   logic              full_q;
   logic              full_d;

   // Load wins over drain; a drain of an empty slot is harmless.
   always_comb begin
      full_d = full_q;
      if (drain_i) full_d = 1'b0;
      if (load_i)  full_d = 1'b1;
   end

   // Slot state; data is retained after a drain.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         full_q <= full_d;
         if (load_i) data_q <= data_i;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule : demux_32_slot

// File: rtl/demux_32_buf.sv
// Buffered 1-to-4 demultiplexer with one single-entry slot per destination.
// Optional feature: define DEMUX_32_BUF_CNT_EN to enable the accepted-word
// counter on acc_cnt; otherwise acc_cnt is tied to zero.
module demux_32_buf
   import demux_32_buf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] S,
   input  logic [1:0]        ctrl,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] C,
   output logic [DATA_W-1:0] D,
   output logic [N_DEST-1:0] out_valid,
   input  logic [N_DEST-1:0] out_ready,
   output logic [CNT_W-1:0]  acc_cnt
);

   logic [N_DEST-1:0] full;
   logic [N_DEST-1:0] load;
   logic [DATA_W-1:0] slot_data [N_DEST];
   logic              accept;

   // Selected slot can take a word if empty or being drained this cycle.
   assign in_ready = !full[ctrl] || out_ready[ctrl];
   assign accept   = in_valid && in_ready;

   for (genvar i = 0; i < N_DEST; i++) begin : g_slot
      localparam logic [1:0] Idx = 2'(i);

      assign load[i] = accept && (ctrl == Idx);

      demux_32_slot u_slot (
         .clk_i   (clk),
         .rst_ni  (rst_n),
         .load_i  (load[i]),
         .drain_i (out_ready[i]),
         .data_i  (S),
         .data_o  (slot_data[i]),
         .full_o  (full[i])
      );
   end

   assign out_valid = full;
   assign A         = slot_data[CH_A];
   assign B         = slot_data[CH_B];
   assign C         = slot_data[CH_C];
   assign D         = slot_data[CH_D];

`ifdef DEMUX_32_BUF_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Count accepted words, wrapping naturally at the counter width.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign acc_cnt = cnt_q;
`else
   assign acc_cnt = '0;
`endif

endmodule : demux_32_buf

// File: tb/tb_demux_32_buf.sv
// Self-checking bench for demux_32_buf: fixed vector table, hand-written
// backpressure/parallel-drain sequences, and random traffic against a model.
module tb_demux_32_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] S;
   logic [1:0]  ctrl;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A, B, C, D;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [15:0] acc_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: per-destination word and occupancy, plus accept count.
   logic [31:0] mdata [4];
   logic        mfull [4];
   logic [15:0] mcnt;

   always #5 clk = ~clk;

   demux_32_buf dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .S         (S),
      .ctrl      (ctrl),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_cnt   (acc_cnt)
   );

   typedef struct {
      logic        r;
      logic        iv;
      logic [1:0]  c;
      logic [31:0] s;
      logic [3:0]  o;
      logic        rdy;
      logic [3:0]  v;
      logic [31:0] a, b, cc, d;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model();
      logic [3:0]  ev;
      logic [15:0] ec;
      for (int i = 0; i < 4; i++) ev[i] = mfull[i];
`ifdef DEMUX_32_BUF_CNT_EN
      ec = mcnt;
`else
      ec = 16'h0;
`endif
      chk("out_valid", {28'h0, out_valid}, {28'h0, ev});
      chk("A", A, mdata[0]);
      chk("B", B, mdata[1]);
      chk("C", C, mdata[2]);
      chk("D", D, mdata[3]);
      chk("acc_cnt", {16'h0, acc_cnt}, {16'h0, ec});
   endtask

   // Apply one cycle of inputs, check in_ready, clock, then check all outputs.
   task automatic drive(input logic r, input logic iv, input logic [1:0] c,
                        input logic [31:0] s, input logic [3:0] o);
      logic rdy;
      rst_n = r; in_valid = iv; ctrl = c; S = s; out_ready = o;
      #1;
      rdy = !mfull[c] || o[c];
      chk("in_ready", {31'h0, in_ready}, {31'h0, rdy});
      if (!r) begin
         for (int i = 0; i < 4; i++) begin mfull[i] = 1'b0; mdata[i] = '0; end
         mcnt = '0;
      end else begin
         for (int i = 0; i < 4; i++) if (o[i]) mfull[i] = 1'b0;
         if (iv && rdy) begin
            mfull[c] = 1'b1;
            mdata[c] = s;
            mcnt     = mcnt + 16'd1;
         end
      end
      tick();
      check_model();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; ctrl = 2'd0; S = '0; out_ready = '0;
      for (int i = 0; i < 4; i++) begin mfull[i] = 1'b0; mdata[i] = '0; end
      mcnt = '0;

      //          r   iv  c   s             o        rdy v        A      B      C             D
      tbl[0]  = '{1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0100, 32'h0, 32'h0,  32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 2'd1, 32'h000000B0, 4'b0000, 1'b1, 4'b0110, 32'h0, 32'hB0, 32'hDEADBEEF, 32'h0};
      tbl[2]  = '{1'b1, 1'b1, 2'd1, 32'h00000001, 4'b0000, 1'b0, 4'b0110, 32'h0, 32'hB0, 32'hDEADBEEF, 32'h0};
      tbl[3]  = '{1'b1, 1'b1, 2'd1, 32'h00000001, 4'b0000, 1'b0, 4'b0110, 32'h0, 32'hB0, 32'hDEADBEEF, 32'h0};
      tbl[4]  = '{1'b1, 1'b1, 2'd1, 32'h00000001, 4'b0010, 1'b1, 4'b0110, 32'h0, 32'h1,  32'hDEADBEEF, 32'h0};
      tbl[5]  = '{1'b1, 1'b0, 2'd0, 32'hFFFFFFFF, 4'b0000, 1'b1, 4'b0110, 32'h0, 32'h1,  32'hDEADBEEF, 32'h0};
      tbl[6]  = '{1'b1, 1'b0, 2'd1, 32'h00000000, 4'b0110, 1'b1, 4'b0000, 32'h0, 32'h1,  32'hDEADBEEF, 32'h0};
      tbl[7]  = '{1'b1, 1'b1, 2'd0, 32'h00000001, 4'b1111, 1'b1, 4'b0001, 32'h1, 32'h1,  32'hDEADBEEF, 32'h0};
      tbl[8]  = '{1'b1, 1'b1, 2'd3, 32'h00000004, 4'b0000, 1'b1, 4'b1001, 32'h1, 32'h1,  32'hDEADBEEF, 32'h4};
      tbl[9]  = '{1'b0, 1'b1, 2'd1, 32'h00000007, 4'b0000, 1'b1, 4'b0000, 32'h0, 32'h0,  32'h0,        32'h0};
      tbl[10] = '{1'b1, 1'b0, 2'd3, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 32'h0, 32'h0,  32'h0,        32'h0};

      // Reset state.
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst out_valid", {28'h0, out_valid}, 32'h0);
      chk("rst A", A, 32'h0);
      chk("rst B", B, 32'h0);
      chk("rst C", C, 32'h0);
      chk("rst D", D, 32'h0);
      chk("rst acc_cnt", {16'h0, acc_cnt}, 32'h0);

      // Fixed vector table.
      for (int k = 0; k < 11; k++) begin
         rst_n = tbl[k].r; in_valid = tbl[k].iv; ctrl = tbl[k].c;
         S = tbl[k].s; out_ready = tbl[k].o;
         #1;
         chk($sformatf("tbl%0d in_ready", k), {31'h0, in_ready}, {31'h0, tbl[k].rdy});
         tick();
         chk($sformatf("tbl%0d out_valid", k), {28'h0, out_valid}, {28'h0, tbl[k].v});
         chk($sformatf("tbl%0d A", k), A, tbl[k].a);
         chk($sformatf("tbl%0d B", k), B, tbl[k].b);
         chk($sformatf("tbl%0d C", k), C, tbl[k].cc);
         chk($sformatf("tbl%0d D", k), D, tbl[k].d);
      end

      // Backpressure on B held for five cycles, then released in the same cycle.
      drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
      drive(1'b1, 1'b1, 2'd1, 32'h000000B0, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b1, 2'd1, 32'h00000001, 4'b0000);
         chk("bp B held", B, 32'hB0);
      end
      drive(1'b1, 1'b1, 2'd1, 32'h00000001, 4'b0010);
      chk("bp B new", B, 32'h1);
      chk("bp valid1", {31'h0, out_valid[1]}, 32'h1);

      // Parallel drain of all four slots.
      drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
      for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 2'(k), 32'(k + 1), 4'b0000);
      chk("par full", {28'h0, out_valid}, 32'hF);
      drive(1'b1, 1'b0, 2'd0, 32'h0, 4'b1111);
      chk("par valid", {28'h0, out_valid}, 32'h0);
      chk("par data", {A[7:0], B[7:0], C[7:0], D[7:0]}, 32'h01020304);

      // Mid-operation reset with A and D full.
      drive(1'b1, 1'b1, 2'd0, 32'hAAAA5555, 4'b0000);
      drive(1'b1, 1'b1, 2'd3, 32'h5555AAAA, 4'b0000);
      drive(1'b0, 1'b0, 2'd1, 32'h0, 4'b0000);
      chk("midrst valid", {28'h0, out_valid}, 32'h0);
      chk("midrst A", A, 32'h0);
      chk("midrst D", D, 32'h0);

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         drive(($urandom_range(0, 49) != 0), 1'($urandom), 2'($urandom),
               $urandom, 4'($urandom));
      end

`ifdef DEMUX_32_BUF_CNT_EN
      // Counter wrap: 65537 accepts land on 1.
      drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
      in_valid = 1'b1; ctrl = 2'd0; S = 32'h12345678; out_ready = 4'b0001;
      repeat (65537) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("cnt wrap", {16'h0, acc_cnt}, 32'h1);
`else
      chk("cnt tied", {16'h0, acc_cnt}, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_demux_32_buf

// File: doc/demux_32_buf.md
DEMUX_32_BUF -- requirements
Module: demux_32_buf

Interface
REQ-001 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port S  input  32  source data word.
REQ-004 SHALL have port ctrl  input  2  destination select: 0=A, 1=B, 2=C, 3=D.
REQ-005 SHALL have port in_valid  input  1  S/ctrl valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts S this cycle.
REQ-007 SHALL have ports A, B, C, D  output  32 each  per-destination held data.
REQ-008 SHALL have port out_valid  output  4  bit i = destination i holds an undelivered word (bit0=A .. bit3=D).
REQ-009 SHALL have port out_ready  input  4  bit i = destination i consumes its word this cycle.
REQ-010 SHALL have port acc_cnt  output  16  accepted-word count (see Configuration).

Function
REQ-011 SHALL keep one single-entry slot per destination: 32-bit data register plus full flag; out_valid[i] = full[i]; A..D driven directly from slot data registers.
REQ-012 SHALL drive in_ready = !full[ctrl] || out_ready[ctrl], combinationally, independent of in_valid.
REQ-013 SHALL accept when in_valid && in_ready: slot[ctrl] data <= S, full[ctrl] <= 1 on the next edge; latency S-to-valid exactly 1 cycle.
REQ-014 SHALL drain slot i when full[i] && out_ready[i]: full[i] <= 0 unless the same cycle accepts into slot i, in which case full[i] stays 1 and data takes the new S (no bubble, no loss).
REQ-015 SHALL hold slot data and out_valid[i] stable while full[i] && !out_ready[i]; in_ready low for that ctrl; S not written.
REQ-016 SHALL leave slots other than ctrl unaffected by an accept; drains on all four slots proceed in parallel in the same cycle.
REQ-017 SHALL retain last data on A..D after drain (outputs not zeroed); out_ready[i] with full[i]=0 SHALL have no effect.
REQ-018 SHALL ignore S and ctrl when in_valid=0; ctrl changing while in_valid=0 causes no state change.

Reset
REQ-019 SHALL, when rst_n=0 at a clock edge, clear all full flags, set A, B, C, D to 32'h0, acc_cnt to 0; out_valid = 4'b0000 the cycle after.
REQ-020 SHALL discard any in-flight word accepted or held when reset asserts mid-operation; in_ready is 1 during and after reset (all slots empty).

Configuration
REQ-021 SHALL, with macro DEMUX_32_BUF_CNT_EN defined, increment acc_cnt by 1 on every accepted word, wrapping 16'hFFFF -> 16'h0000.
REQ-022 SHALL, without DEMUX_32_BUF_CNT_EN, tie acc_cnt to 16'h0000 and instantiate no counter logic; all other behaviour identical.

Structure
REQ-023 SHALL place data width (32), destination count (4), and destination index constants CH_A=0, CH_B=1, CH_C=2, CH_D=3 in the shared package.
REQ-024 SHALL implement each slot as sub-module demux_32_slot (load, drain, data in, data out, full), instantiated four times.

Verification
REQ-025 Reset: rst_n=0 one cycle, then 1 -> out_valid=0000, A..D=0, in_ready=1, acc_cnt=0.
REQ-026 Single route: in_valid=1, ctrl=2, S=32'hDEADBEEF, out_ready=0000 -> next cycle C=32'hDEADBEEF, out_valid=0100; A, B, D unchanged.
REQ-027 Backpressure: slot B full, out_ready[1]=0, in_valid=1, ctrl=1, S=32'h1 -> in_ready=0, B unchanged for 5 cycles; raise out_ready[1] same cycle -> in_ready=1, B=32'h1 next cycle, out_valid[1] stays 1.
REQ-028 Parallel: fill A..D with 1,2,3,4, then out_ready=1111 one cycle -> out_valid=0000, A..D still 1,2,3,4.
REQ-029 Mid-op reset: slots A and D full, assert rst_n=0 -> next cycle out_valid=0000, A=D=0.
REQ-030 Counter (DEMUX_32_BUF_CNT_EN defined): preload via 65537 accepted words -> acc_cnt=16'h0001; macro undefined -> acc_cnt=0 throughout.
